// File: rtl/alu_rs_sched.sv
// Reservation station and issue scheduler for the single ALU: buffers dispatched
// instructions, snoops the ALU/LSB result buses, and issues the lowest-index ready entry.
module alu_rs_sched #(
    parameter int RS_SIZE = 8,
    parameter int ROB_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rdy,
    input  logic             rollback,
    input  logic             in_valid,
    input  logic [ROB_W-1:0] in_rob_pos,
    input  logic [6:0]       in_opcode,
    input  logic [2:0]       in_funct3,
    input  logic             in_funct7,
    input  logic             in_q1_busy,
    input  logic [ROB_W-1:0] in_q1,
    input  logic [31:0]      in_v1,
    input  logic             in_q2_busy,
    input  logic [ROB_W-1:0] in_q2,
    input  logic [31:0]      in_v2,
    input  logic [31:0]      in_imm,
    input  logic [31:0]      in_pc,
    output logic             rs_full,
    input  logic             alu_cdb_valid,
    input  logic [ROB_W-1:0] alu_cdb_rob_pos,
    input  logic [31:0]      alu_cdb_val,
    input  logic             lsb_cdb_valid,
    input  logic [ROB_W-1:0] lsb_cdb_rob_pos,
    input  logic [31:0]      lsb_cdb_val,
    output logic             alu_en,
    output logic [ROB_W-1:0] alu_rob_pos,
    output logic [6:0]       alu_opcode,
    output logic [2:0]       alu_funct3,
    output logic             alu_funct7,
    output logic [31:0]      alu_val1,
    output logic [31:0]      alu_val2,
    output logic [31:0]      alu_imm,
    output logic [31:0]      alu_pc
);

    localparam int IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0] busy;
    logic [RS_SIZE-1:0] q1_busy;
    logic [RS_SIZE-1:0] q2_busy;
    logic [ROB_W-1:0]   q1      [RS_SIZE];
    logic [ROB_W-1:0]   q2      [RS_SIZE];
    logic [31:0]        v1      [RS_SIZE];
    logic [31:0]        v2      [RS_SIZE];
    logic [ROB_W-1:0]   rob_pos [RS_SIZE];
    logic [6:0]         opcode  [RS_SIZE];
    logic [2:0]         funct3  [RS_SIZE];
    logic               funct7  [RS_SIZE];
    logic [31:0]        imm     [RS_SIZE];
    logic [31:0]        pc      [RS_SIZE];

    logic [RS_SIZE-1:0] ready;
    logic [RS_SIZE-1:0] free_mask;
    logic               issue_hit;
    logic [IDX_W-1:0]   issue_idx;
    logic               free_hit;
    logic [IDX_W-1:0]   free_idx;
    logic               byp1_busy;
    logic [31:0]        byp1_val;
    logic               byp2_busy;
    logic [31:0]        byp2_val;

    assign rs_full = &busy;

    // Priority pick of issue slot and dispatch slot; the issuing slot counts as free
    // so a dispatch may reuse it on the same edge.
    always_comb begin
        ready     = busy & ~q1_busy & ~q2_busy;
        issue_hit = 1'b0;
        issue_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i]) begin
                issue_hit = 1'b1;
                issue_idx = IDX_W'(i);
            end
        end
        free_mask = ~busy;
        if (issue_hit) free_mask[issue_idx] = 1'b1;
        free_hit = 1'b0;
        free_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (free_mask[i]) begin
                free_hit = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        byp1_busy = in_q1_busy;
        byp1_val  = in_v1;
        if (in_q1_busy && alu_cdb_valid && alu_cdb_rob_pos == in_q1) begin
            byp1_busy = 1'b0;
            byp1_val  = alu_cdb_val;
        end else if (in_q1_busy && lsb_cdb_valid && lsb_cdb_rob_pos == in_q1) begin
            byp1_busy = 1'b0;
            byp1_val  = lsb_cdb_val;
        end
        byp2_busy = in_q2_busy;
        byp2_val  = in_v2;
        if (in_q2_busy && alu_cdb_valid && alu_cdb_rob_pos == in_q2) begin
            byp2_busy = 1'b0;
            byp2_val  = alu_cdb_val;
        end else if (in_q2_busy && lsb_cdb_valid && lsb_cdb_rob_pos == in_q2) begin
            byp2_busy = 1'b0;
            byp2_val  = lsb_cdb_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= '0;
            q1_busy     <= '0;
            q2_busy     <= '0;
            alu_en      <= 1'b0;
            alu_rob_pos <= '0;
            alu_opcode  <= '0;
            alu_funct3  <= '0;
            alu_funct7  <= 1'b0;
            alu_val1    <= '0;
            alu_val2    <= '0;
            alu_imm     <= '0;
            alu_pc      <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                q1[i]      <= '0;
                q2[i]      <= '0;
                v1[i]      <= '0;
                v2[i]      <= '0;
                rob_pos[i] <= '0;
                opcode[i]  <= '0;
                funct3[i]  <= '0;
                funct7[i]  <= 1'b0;
                imm[i]     <= '0;
                pc[i]      <= '0;
            end
        end else if (rdy) begin
            if (rollback) begin
                busy   <= '0;
                alu_en <= 1'b0;
            end else begin
                alu_en <= issue_hit;
                if (issue_hit) begin
                    alu_rob_pos     <= rob_pos[issue_idx];
                    alu_opcode      <= opcode[issue_idx];
                    alu_funct3      <= funct3[issue_idx];
                    alu_funct7      <= funct7[issue_idx];
                    alu_val1        <= v1[issue_idx];
                    alu_val2        <= v2[issue_idx];
                    alu_imm         <= imm[issue_idx];
                    alu_pc          <= pc[issue_idx];
                    busy[issue_idx] <= 1'b0;
                end
                // Wakeup; the ALU bus is checked first so it wins on a double match.
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy[i] && q1_busy[i]) begin
                        if (alu_cdb_valid && alu_cdb_rob_pos == q1[i]) begin
                            q1_busy[i] <= 1'b0;
                            v1[i]      <= alu_cdb_val;
                        end else if (lsb_cdb_valid && lsb_cdb_rob_pos == q1[i]) begin
                            q1_busy[i] <= 1'b0;
                            v1[i]      <= lsb_cdb_val;
                        end
                    end
                    if (busy[i] && q2_busy[i]) begin
                        if (alu_cdb_valid && alu_cdb_rob_pos == q2[i]) begin
                            q2_busy[i] <= 1'b0;
                            v2[i]      <= alu_cdb_val;
                        end else if (lsb_cdb_valid && lsb_cdb_rob_pos == q2[i]) begin
                            q2_busy[i] <= 1'b0;
                            v2[i]      <= lsb_cdb_val;
                        end
                    end
                end
                if (in_valid && !rs_full && free_hit) begin
                    busy[free_idx]    <= 1'b1;
                    q1_busy[free_idx] <= byp1_busy;
                    q1[free_idx]      <= in_q1;
                    v1[free_idx]      <= byp1_val;
                    q2_busy[free_idx] <= byp2_busy;
                    q2[free_idx]      <= in_q2;
                    v2[free_idx]      <= byp2_val;
                    rob_pos[free_idx] <= in_rob_pos;
                    opcode[free_idx]  <= in_opcode;
                    funct3[free_idx]  <= in_funct3;
                    funct7[free_idx]  <= in_funct7;
                    imm[free_idx]     <= in_imm;
                    pc[free_idx]      <= in_pc;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_rs_sched.sv
// Self-checking bench for alu_rs_sched: directed scenarios plus randomized traffic
// compared against a slot-array reference model.
module tb_alu_rs_sched;

    localparam int RS = 8;

    logic        clk;
    logic        rst_n;
    logic        rdy;
    logic        rollback;
    logic        in_valid;
    logic [3:0]  in_rob_pos;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic        in_funct7;
    logic        in_q1_busy;
    logic [3:0]  in_q1;
    logic [31:0] in_v1;
    logic        in_q2_busy;
    logic [3:0]  in_q2;
    logic [31:0] in_v2;
    logic [31:0] in_imm;
    logic [31:0] in_pc;
    logic        rs_full;
    logic        alu_cdb_valid;
    logic [3:0]  alu_cdb_rob_pos;
    logic [31:0] alu_cdb_val;
    logic        lsb_cdb_valid;
    logic [3:0]  lsb_cdb_rob_pos;
    logic [31:0] lsb_cdb_val;
    logic        alu_en;
    logic [3:0]  alu_rob_pos;
    logic [6:0]  alu_opcode;
    logic [2:0]  alu_funct3;
    logic        alu_funct7;
    logic [31:0] alu_val1;
    logic [31:0] alu_val2;
    logic [31:0] alu_imm;
    logic [31:0] alu_pc;

    alu_rs_sched #(.RS_SIZE(RS), .ROB_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .rollback(rollback),
        .in_valid(in_valid), .in_rob_pos(in_rob_pos), .in_opcode(in_opcode),
        .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_q1_busy(in_q1_busy), .in_q1(in_q1), .in_v1(in_v1),
        .in_q2_busy(in_q2_busy), .in_q2(in_q2), .in_v2(in_v2),
        .in_imm(in_imm), .in_pc(in_pc), .rs_full(rs_full),
        .alu_cdb_valid(alu_cdb_valid), .alu_cdb_rob_pos(alu_cdb_rob_pos), .alu_cdb_val(alu_cdb_val),
        .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_rob_pos(lsb_cdb_rob_pos), .lsb_cdb_val(lsb_cdb_val),
        .alu_en(alu_en), .alu_rob_pos(alu_rob_pos), .alu_opcode(alu_opcode),
        .alu_funct3(alu_funct3), .alu_funct7(alu_funct7), .alu_val1(alu_val1),
        .alu_val2(alu_val2), .alu_imm(alu_imm), .alu_pc(alu_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          busy;
        bit          q1b;
        logic [3:0]  q1;
        logic [31:0] v1;
        bit          q2b;
        logic [3:0]  q2;
        logic [31:0] v2;
        logic [3:0]  rob;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] imm;
        logic [31:0] pc;
    } ent_t;

    ent_t        m [RS];
    logic        e_en;
    logic [3:0]  e_rob;
    logic [6:0]  e_op;
    logic [2:0]  e_f3;
    logic        e_f7;
    logic [31:0] e_v1;
    logic [31:0] e_v2;
    logic [31:0] e_imm;
    logic [31:0] e_pc;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit modelFull();
        bit f = 1'b1;
        for (int i = 0; i < RS; i++) if (!m[i].busy) f = 1'b0;
        return f;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < RS; i++) m[i] = '{default: '0};
        e_en = 0; e_rob = 0; e_op = 0; e_f3 = 0; e_f7 = 0;
        e_v1 = 0; e_v2 = 0; e_imm = 0; e_pc = 0;
    endtask

    // Resolve an operand against the two buses: returns still-pending flag and value.
    task automatic resolve(input bit pend, input logic [3:0] tag, input logic [31:0] val,
                           output bit pend_o, output logic [31:0] val_o);
        pend_o = pend;
        val_o  = val;
        if (pend && alu_cdb_valid && alu_cdb_rob_pos == tag) begin
            pend_o = 0; val_o = alu_cdb_val;
        end else if (pend && lsb_cdb_valid && lsb_cdb_rob_pos == tag) begin
            pend_o = 0; val_o = lsb_cdb_val;
        end
    endtask

    task automatic modelStep();
        ent_t nxt [RS];
        int   sel;
        int   slot;
        bit   full;
        if (!rdy) return;
        if (rollback) begin
            for (int i = 0; i < RS; i++) m[i].busy = 0;
            e_en = 0;
            return;
        end
        full = modelFull();
        sel  = -1;
        for (int i = 0; i < RS; i++)
            if (sel < 0 && m[i].busy && !m[i].q1b && !m[i].q2b) sel = i;
        nxt = m;
        if (sel >= 0) begin
            e_en = 1; e_rob = m[sel].rob; e_op = m[sel].op; e_f3 = m[sel].f3;
            e_f7 = m[sel].f7; e_v1 = m[sel].v1; e_v2 = m[sel].v2;
            e_imm = m[sel].imm; e_pc = m[sel].pc;
            nxt[sel].busy = 0;
        end else begin
            e_en = 0;
        end
        for (int i = 0; i < RS; i++) begin
            if (m[i].busy) begin
                resolve(m[i].q1b, m[i].q1, m[i].v1, nxt[i].q1b, nxt[i].v1);
                resolve(m[i].q2b, m[i].q2, m[i].v2, nxt[i].q2b, nxt[i].v2);
            end
        end
        if (in_valid && !full) begin
            slot = -1;
            for (int i = 0; i < RS; i++) if (slot < 0 && !nxt[i].busy) slot = i;
            nxt[slot].busy = 1;
            nxt[slot].q1 = in_q1;  nxt[slot].q2 = in_q2;
            resolve(in_q1_busy, in_q1, in_v1, nxt[slot].q1b, nxt[slot].v1);
            resolve(in_q2_busy, in_q2, in_v2, nxt[slot].q2b, nxt[slot].v2);
            nxt[slot].rob = in_rob_pos; nxt[slot].op = in_opcode; nxt[slot].f3 = in_funct3;
            nxt[slot].f7 = in_funct7; nxt[slot].imm = in_imm; nxt[slot].pc = in_pc;
        end
        m = nxt;
    endtask

    task automatic checkAgainstModel();
        checkOutput("alu_en",      32'(alu_en),      32'(e_en));
        checkOutput("alu_rob_pos", 32'(alu_rob_pos), 32'(e_rob));
        checkOutput("alu_opcode",  32'(alu_opcode),  32'(e_op));
        checkOutput("alu_funct3",  32'(alu_funct3),  32'(e_f3));
        checkOutput("alu_funct7",  32'(alu_funct7),  32'(e_f7));
        checkOutput("alu_val1",    alu_val1,         e_v1);
        checkOutput("alu_val2",    alu_val2,         e_v2);
        checkOutput("alu_imm",     alu_imm,          e_imm);
        checkOutput("alu_pc",      alu_pc,           e_pc);
    endtask

    task automatic clearInputs();
        rdy = 1; rollback = 0; in_valid = 0; in_rob_pos = 0; in_opcode = 0;
        in_funct3 = 0; in_funct7 = 0; in_q1_busy = 0; in_q1 = 0; in_v1 = 0;
        in_q2_busy = 0; in_q2 = 0; in_v2 = 0; in_imm = 0; in_pc = 0;
        alu_cdb_valid = 0; alu_cdb_rob_pos = 0; alu_cdb_val = 0;
        lsb_cdb_valid = 0; lsb_cdb_rob_pos = 0; lsb_cdb_val = 0;
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic applyStimulus();
        #1;
        checkOutput("rs_full", 32'(rs_full), 32'(modelFull()));
        modelStep();
        @(posedge clk);
        #1;
        checkAgainstModel();
        @(negedge clk);
    endtask

    task automatic dispatchOne(input logic [3:0] rob, input bit q1b, input logic [3:0] q1,
                               input logic [31:0] v1, input bit q2b, input logic [3:0] q2,
                               input logic [31:0] v2);
        in_valid = 1; in_rob_pos = rob; in_opcode = 7'b0110011; in_funct3 = 3'd0;
        in_funct7 = 0; in_q1_busy = q1b; in_q1 = q1; in_v1 = v1;
        in_q2_busy = q2b; in_q2 = q2; in_v2 = v2;
        in_imm = 32'h100 + 32'(rob); in_pc = 32'h1000 + 32'(rob) * 4;
        applyStimulus();
        in_valid = 0;
    endtask

    task automatic randomInputs();
        rdy        = ($urandom_range(0, 9) != 0);
        rollback   = ($urandom_range(0, 59) == 0);
        in_valid   = ($urandom_range(0, 2) != 0);
        in_rob_pos = 4'($urandom);
        in_opcode  = 7'($urandom);
        in_funct3  = 3'($urandom);
        in_funct7  = 1'($urandom);
        in_q1_busy = ($urandom_range(0, 2) == 0);
        in_q1      = 4'($urandom);
        in_v1      = $urandom;
        in_q2_busy = ($urandom_range(0, 2) == 0);
        in_q2      = 4'($urandom);
        in_v2      = $urandom;
        in_imm     = $urandom;
        in_pc      = $urandom;
        alu_cdb_valid   = ($urandom_range(0, 1) == 1);
        alu_cdb_rob_pos = 4'($urandom);
        alu_cdb_val     = $urandom;
        lsb_cdb_valid   = ($urandom_range(0, 1) == 1);
        lsb_cdb_rob_pos = 4'($urandom);
        lsb_cdb_val     = $urandom;
        if (alu_cdb_valid && lsb_cdb_valid && alu_cdb_rob_pos == lsb_cdb_rob_pos)
            lsb_cdb_rob_pos = alu_cdb_rob_pos + 4'd1;
    endtask

    initial begin
        clearInputs();
        modelReset();
        rst_n = 0;
        #2;
        checkAgainstModel();
        checkOutput("reset_full", 32'(rs_full), 32'd0);
        @(negedge clk);
        rst_n = 1;

        // Ready ADD issues two edges after dispatch, then alu_en drops.
        dispatchOne(4'd3, 0, 4'd0, 32'd5, 0, 4'd0, 32'd7);
        checkOutput("t1_en_early", 32'(alu_en), 32'd0);
        applyStimulus();
        checkOutput("t1_en", 32'(alu_en), 32'd1);
        checkOutput("t1_rob", 32'(alu_rob_pos), 32'd3);
        checkOutput("t1_v1", alu_val1, 32'd5);
        checkOutput("t1_v2", alu_val2, 32'd7);
        applyStimulus();
        checkOutput("t1_en_drop", 32'(alu_en), 32'd0);

        // Wakeup from the ALU bus.
        dispatchOne(4'd4, 1, 4'd6, 32'd0, 0, 4'd0, 32'd1);
        applyStimulus();
        alu_cdb_valid = 1; alu_cdb_rob_pos = 4'd6; alu_cdb_val = 32'h11;
        applyStimulus();
        alu_cdb_valid = 0;
        checkOutput("t2_en_wait", 32'(alu_en), 32'd0);
        applyStimulus();
        checkOutput("t2_en", 32'(alu_en), 32'd1);
        checkOutput("t2_v1", alu_val1, 32'h11);

        // Same-cycle LSB bypass at dispatch.
        lsb_cdb_valid = 1; lsb_cdb_rob_pos = 4'd2; lsb_cdb_val = 32'd9;
        dispatchOne(4'd5, 0, 4'd0, 32'd1, 1, 4'd2, 32'd0);
        lsb_cdb_valid = 0;
        applyStimulus();
        checkOutput("t3_en", 32'(alu_en), 32'd1);
        checkOutput("t3_v2", alu_val2, 32'd9);
        applyStimulus();

        // Fill all slots pending on tags 8..15; wake slots 5 and 1 together.
        for (int i = 0; i < RS; i++) dispatchOne(4'(i), 1, 4'(i + 8), 32'd0, 0, 4'd0, 32'(i));
        checkOutput("t4_full", 32'(rs_full), 32'd1);
        checkOutput("t4_no_en", 32'(alu_en), 32'd0);
        alu_cdb_valid = 1; alu_cdb_rob_pos = 4'd13; alu_cdb_val = 32'h55;
        lsb_cdb_valid = 1; lsb_cdb_rob_pos = 4'd9;  lsb_cdb_val = 32'h11;
        applyStimulus();
        alu_cdb_valid = 0; lsb_cdb_valid = 0;
        applyStimulus();
        checkOutput("t4_first_rob", 32'(alu_rob_pos), 32'd1);
        checkOutput("t4_first_v1", alu_val1, 32'h11);
        checkOutput("t4_not_full", 32'(rs_full), 32'd0);
        applyStimulus();
        checkOutput("t4_second_rob", 32'(alu_rob_pos), 32'd5);
        checkOutput("t4_second_en", 32'(alu_en), 32'd1);

        // Rollback discards everything; old tags then wake nothing.
        rollback = 1;
        applyStimulus();
        rollback = 0;
        checkOutput("t5_en", 32'(alu_en), 32'd0);
        checkOutput("t5_full", 32'(rs_full), 32'd0);
        for (int t = 8; t < 16; t++) begin
            alu_cdb_valid = 1; alu_cdb_rob_pos = 4'(t); alu_cdb_val = 32'(t);
            applyStimulus();
            checkOutput("t5_no_issue", 32'(alu_en), 32'd0);
        end
        alu_cdb_valid = 0;

        for (int c = 0; c < 3000; c++) begin
            randomInputs();
            applyStimulus();
        end
        clearInputs();

        // Asynchronous reset takes effect between edges.
        rst_n = 0;
        #2;
        modelReset();
        checkAgainstModel();
        checkOutput("async_full", 32'(rs_full), 32'd0);
        #1;
        rst_n = 1;
        @(negedge clk);

        // rdy low freezes a ready entry; it issues on the first edge after rdy returns.
        dispatchOne(4'd9, 0, 4'd0, 32'hAB, 0, 4'd0, 32'hCD);
        rdy = 0;
        for (int c = 0; c < 3; c++) begin
            applyStimulus();
            checkOutput("t6_frozen", 32'(alu_en), 32'd0);
        end
        rdy = 1;
        applyStimulus();
        checkOutput("t6_en", 32'(alu_en), 32'd1);
        checkOutput("t6_rob", 32'(alu_rob_pos), 32'd9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
